// File: rtl/sprite_rom_arbiter.sv
// Shared sprite ROM arbiter: three requesters, one read per cycle, data returned one cycle after grant.
// Define SPRITE_ARB_FIXED_PRI_EN for fixed priority (0 > 1 > 2) in place of round-robin.

module sprite_rom_lane #(
  parameter int AW     = 17,
  parameter int STAGES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gnt,
  input  logic [AW-1:0] addr,
  output logic [AW-1:0] addr_sel,
  output logic          rvalid
);
  logic [STAGES:0] vld_pipe;

  assign vld_pipe[0] = gnt;
  assign addr_sel    = gnt ? addr : '0;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe[STAGES:1] <= '0;
    else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // A read granted just before reset must never surface while reset is held.
  assign rvalid = vld_pipe[STAGES] & ~rst;
endmodule

module sprite_rom_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [16:0] addr0,
  input  logic [16:0] addr1,
  input  logic [16:0] addr2,
  input  logic        frame_start,
  output logic [2:0]  gnt,
  output logic        rom_en,
  output logic [16:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] rdata,
  output logic [2:0]  rvalid
);
  localparam int NUM_LANES = 3;
  localparam int AW        = 17;
  localparam int IW        = $clog2(NUM_LANES);

  typedef struct packed {
    logic [NUM_LANES-1:0] gnt;
    logic [IW-1:0]        idx;
    logic                 vld;
  } arb_t;

  arb_t                           arb;
  logic [NUM_LANES-1:0][AW-1:0]   addr_vec;
  logic [NUM_LANES-1:0][AW-1:0]   addr_sel;

  assign addr_vec = {addr2, addr1, addr0};

`ifdef SPRITE_ARB_FIXED_PRI_EN
  logic unused_frame_start;
  assign unused_frame_start = frame_start;

  always_comb begin
    arb = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!arb.vld && req[k] && !rst) begin
        arb.gnt[k] = 1'b1;
        arb.idx    = IW'(k);
        arb.vld    = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] ptr;
  logic [IW-1:0] start;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Search begins one past the last winner, wrapping modulo NUM_LANES.
  assign start = (ptr == IW'(NUM_LANES - 1)) ? '0 : ptr + 1'b1;

  always_comb begin
    arb = '0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      sum = {1'b0, start} + (IW+1)'(k);
      idx = (sum >= (IW+1)'(NUM_LANES)) ? IW'(sum - (IW+1)'(NUM_LANES)) : sum[IW-1:0];
      if (!arb.vld && req[idx] && !rst) begin
        arb.gnt[idx] = 1'b1;
        arb.idx      = idx;
        arb.vld      = 1'b1;
      end
    end
  end

  // frame_start wins over the grant so each frame restarts its search at requester 0.
  always_ff @(posedge clk) begin
    if (rst)              ptr <= IW'(NUM_LANES - 1);
    else if (frame_start) ptr <= IW'(NUM_LANES - 1);
    else if (arb.vld)     ptr <= arb.idx;
  end
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sprite_rom_lane #(.AW(AW), .STAGES(1)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .gnt      (arb.gnt[i]),
      .addr     (addr_vec[i]),
      .addr_sel (addr_sel[i]),
      .rvalid   (rvalid[i])
    );
  end

  // Grant is one-hot, so OR-reducing the masked lane addresses is a mux.
  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < NUM_LANES; i++) rom_addr = rom_addr | addr_sel[i];
  end

  assign gnt    = arb.gnt;
  assign rom_en = arb.vld;
  assign rdata  = (rvalid != '0) ? rom_data : 12'h000;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: inputs change on negedge, outputs sampled 1ns later.
module tb_sprite_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [16:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic        frame_start = 1'b0;
  logic [2:0]  gnt;
  logic        rom_en;
  logic [16:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic [11:0] rdata;
  logic [2:0]  rvalid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] cyc = '0;
  logic [2:0]  exp_rv = 3'b000;
  logic [11:0] exp_rd = 12'h000;

  sprite_rom_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .frame_start(frame_start), .gnt(gnt), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .rdata(rdata), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(input logic [16:0] a);
    return a[11:0] ^ 12'hEDA ^ {7'b0, a[16:12]};
  endfunction

  // ROM model: data for the address presented at an edge appears after that edge.
  always @(posedge clk) rom_data <= rom_f(rom_addr);

  function automatic logic [16:0] exp_addr(input logic [2:0] g);
    if (g[0]) return addr0;
    if (g[1]) return addr1;
    if (g[2]) return addr2;
    return 17'h0;
  endfunction

  task automatic drive(input logic [2:0] r, input logic fs, input logic rs);
    @(negedge clk);
    cyc         = cyc + 12'd1;
    req         = r;
    frame_start = fs;
    rst         = rs;
    addr0       = {5'h00, cyc};
    addr1       = {5'h01, cyc};
    addr2       = {5'h1F, cyc};
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(3'b111, 1'b0, 1'b1);
      n_checks++; if (gnt !== 3'b000)     begin n_fail++; $display("FAIL reset_gnt actual=%b required=000", gnt); end
      n_checks++; if (rom_en !== 1'b0)    begin n_fail++; $display("FAIL reset_rom_en actual=%b required=0", rom_en); end
      n_checks++; if (rom_addr !== 17'h0) begin n_fail++; $display("FAIL reset_rom_addr actual=%h required=0", rom_addr); end
      n_checks++; if (rvalid !== 3'b000)  begin n_fail++; $display("FAIL reset_rvalid actual=%b required=000", rvalid); end
      n_checks++; if (rdata !== 12'h000)  begin n_fail++; $display("FAIL reset_rdata actual=%h required=000", rdata); end
    end
    exp_rv = 3'b000;
  endtask

  // Round-robin sweep out of reset: 001,010,100 repeating, new address every cycle.
  task automatic test_round_robin;
    logic [2:0] eg;
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, 1'b0, 1'b0);
      eg = 3'b001 << (i % 3);
      n_checks++; if (gnt !== eg)                 begin n_fail++; $display("FAIL rr_gnt[%0d] actual=%b required=%b", i, gnt, eg); end
      n_checks++; if (rom_en !== 1'b1)            begin n_fail++; $display("FAIL rr_rom_en[%0d] actual=%b required=1", i, rom_en); end
      n_checks++; if (rom_addr !== exp_addr(eg))  begin n_fail++; $display("FAIL rr_rom_addr[%0d] actual=%h required=%h", i, rom_addr, exp_addr(eg)); end
      n_checks++; if (rvalid !== exp_rv)          begin n_fail++; $display("FAIL rr_rvalid[%0d] actual=%b required=%b", i, rvalid, exp_rv); end
      n_checks++; if (rdata !== ((exp_rv != 0) ? exp_rd : 12'h000)) begin n_fail++; $display("FAIL rr_rdata[%0d] actual=%h required=%h", i, rdata, exp_rd); end
      exp_rv = eg;
      exp_rd = rom_f(exp_addr(eg));
    end
  endtask

  task automatic test_single;
    @(negedge clk);
    req = 3'b010; addr0 = 17'h1ABCD; addr1 = 17'h00100; addr2 = 17'h0FFFF;
    #1;
    n_checks++; if (gnt !== 3'b010)        begin n_fail++; $display("FAIL single_gnt actual=%b required=010", gnt); end
    n_checks++; if (rom_addr !== 17'h00100) begin n_fail++; $display("FAIL single_rom_addr actual=%h required=00100", rom_addr); end
    n_checks++; if (rvalid !== exp_rv)     begin n_fail++; $display("FAIL single_prev_rvalid actual=%b required=%b", rvalid, exp_rv); end
    drive(3'b000, 1'b0, 1'b0);
    n_checks++; if (rom_en !== 1'b0)       begin n_fail++; $display("FAIL single_idle_en actual=%b required=0", rom_en); end
    n_checks++; if (rvalid !== 3'b010)     begin n_fail++; $display("FAIL single_rvalid actual=%b required=010", rvalid); end
    n_checks++; if (rdata !== 12'hFDA)     begin n_fail++; $display("FAIL single_rdata actual=%h required=FDA", rdata); end
    exp_rv = 3'b000;
  endtask

  // Idle for 5 cycles, then the pointer must still reflect the grant to requester 1.
  task automatic test_idle;
    for (int i = 0; i < 5; i++) begin
      drive(3'b000, 1'b0, 1'b0);
      n_checks++; if (rom_en !== 1'b0)   begin n_fail++; $display("FAIL idle_rom_en[%0d] actual=%b required=0", i, rom_en); end
      n_checks++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL idle_rvalid[%0d] actual=%b required=000", i, rvalid); end
      n_checks++; if (rdata !== 12'h000) begin n_fail++; $display("FAIL idle_rdata[%0d] actual=%h required=000", i, rdata); end
    end
    drive(3'b111, 1'b0, 1'b0);
    n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL idle_ptr_held actual=%b required=100", gnt); end
    exp_rv = 3'b100;
    exp_rd = rom_f(addr2);
  endtask

  task automatic test_frame_start;
    logic [2:0] rq [5] = '{3'b111, 3'b000, 3'b111, 3'b111, 3'b111};
    logic       fs [5] = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0};
    logic [2:0] eg [5] = '{3'b001, 3'b000, 3'b001, 3'b010, 3'b001};
    for (int i = 0; i < 5; i++) begin
      drive(rq[i], fs[i], 1'b0);
      n_checks++; if (gnt !== eg[i])    begin n_fail++; $display("FAIL fs_gnt[%0d] actual=%b required=%b", i, gnt, eg[i]); end
      n_checks++; if (rvalid !== exp_rv) begin n_fail++; $display("FAIL fs_rvalid[%0d] actual=%b required=%b", i, rvalid, exp_rv); end
      n_checks++; if (rdata !== ((exp_rv != 0) ? exp_rd : 12'h000)) begin n_fail++; $display("FAIL fs_rdata[%0d] actual=%h required=%h", i, rdata, exp_rd); end
      exp_rv = eg[i];
      exp_rd = rom_f(exp_addr(eg[i]));
    end
  endtask

  // A losing request withdrawn before grant leaves nothing behind.
  task automatic test_drop;
    logic [2:0] rq [4] = '{3'b101, 3'b000, 3'b000, 3'b010};
    logic [2:0] eg [4] = '{3'b100, 3'b000, 3'b000, 3'b010};
    for (int i = 0; i < 4; i++) begin
      drive(rq[i], 1'b0, 1'b0);
      n_checks++; if (gnt !== eg[i])     begin n_fail++; $display("FAIL drop_gnt[%0d] actual=%b required=%b", i, gnt, eg[i]); end
      n_checks++; if (rvalid !== exp_rv) begin n_fail++; $display("FAIL drop_rvalid[%0d] actual=%b required=%b", i, rvalid, exp_rv); end
      exp_rv = eg[i];
      exp_rd = rom_f(exp_addr(eg[i]));
    end
  endtask

  task automatic test_reset_mid;
    drive(3'b111, 1'b0, 1'b0);
    n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL rstmid_pre_gnt actual=%b required=100", gnt); end
    for (int i = 0; i < 2; i++) begin
      drive(3'b111, 1'b0, 1'b1);
      n_checks++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL rstmid_rvalid[%0d] actual=%b required=000", i, rvalid); end
      n_checks++; if (gnt !== 3'b000)    begin n_fail++; $display("FAIL rstmid_gnt[%0d] actual=%b required=000", i, gnt); end
      n_checks++; if (rdata !== 12'h000) begin n_fail++; $display("FAIL rstmid_rdata[%0d] actual=%h required=000", i, rdata); end
    end
    drive(3'b110, 1'b0, 1'b0);
    n_checks++; if (gnt !== 3'b010)    begin n_fail++; $display("FAIL rstmid_first_gnt actual=%b required=010", gnt); end
    n_checks++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL rstmid_post_rvalid actual=%b required=000", rvalid); end
    exp_rd = rom_f(addr1);
    drive(3'b000, 1'b0, 1'b0);
    n_checks++; if (rvalid !== 3'b010) begin n_fail++; $display("FAIL rstmid_ret_rvalid actual=%b required=010", rvalid); end
    n_checks++; if (rdata !== exp_rd)  begin n_fail++; $display("FAIL rstmid_ret_rdata actual=%h required=%h", rdata, exp_rd); end
  endtask

  task automatic test_fixed_pri;
    logic [2:0] rq [6] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b110, 3'b100};
    logic [2:0] eg [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 6; i++) begin
      drive(rq[i], 1'b1, 1'b0);
      n_checks++; if (gnt !== eg[i])               begin n_fail++; $display("FAIL fp_gnt[%0d] actual=%b required=%b", i, gnt, eg[i]); end
      n_checks++; if (rom_addr !== exp_addr(eg[i])) begin n_fail++; $display("FAIL fp_rom_addr[%0d] actual=%h required=%h", i, rom_addr, exp_addr(eg[i])); end
      n_checks++; if (rvalid !== exp_rv)           begin n_fail++; $display("FAIL fp_rvalid[%0d] actual=%b required=%b", i, rvalid, exp_rv); end
      exp_rv = eg[i];
    end
  endtask

  initial begin
    test_reset;
`ifdef SPRITE_ARB_FIXED_PRI_EN
    test_fixed_pri;
`else
    test_round_robin;
    test_single;
    test_idle;
    test_frame_start;
    test_drop;
    test_reset_mid;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: req  input  3  per-requester read request; bit0 = player (CY), bit1 = monster_1, bit2 = monster_2.
REQ-004 SHALL have port: addr0, addr1, addr2  input  17 each  ROM word address of each requester.
REQ-005 SHALL have port: frame_start  input  1  one-cycle pulse at start of each VGA frame.
REQ-006 SHALL have port: gnt  output  3  one-hot grant; at most one bit high per cycle.
REQ-007 SHALL have port: rom_en  output  1  shared sprite ROM read enable.
REQ-008 SHALL have port: rom_addr  output  17  shared sprite ROM address.
REQ-009 SHALL have port: rom_data  input  12  ROM read data (12-bit RGB), valid exactly 1 cycle after rom_en.
REQ-010 SHALL have port: rdata  output  12  returned pixel data, shared by all requesters.
REQ-011 SHALL have port: rvalid  output  3  one-hot marker of which requester owns rdata this cycle.

Function
REQ-012 Arbitration is combinational from req and the registered pointer; gnt, rom_en and rom_addr change in the cycle a request is seen.
REQ-013 rom_en SHALL equal OR of gnt; rom_addr SHALL equal the granted requester's address, else 17'h0.
REQ-014 Round-robin: search order starts at (last_grant+1) mod 3; first asserted req in that order wins.
REQ-015 last_grant pointer SHALL update to the granted index on each cycle with rom_en=1; unchanged otherwise.
REQ-016 gnt[i] high means addr_i is consumed this cycle; requester may keep req high for back-to-back reads with a new address.
REQ-017 rvalid SHALL be gnt registered by one cycle; rdata SHALL equal rom_data when rvalid != 0, else 12'h000.
REQ-018 Read latency: gnt cycle N -> rvalid/rdata cycle N+1; throughput one read per cycle total.
REQ-019 Fairness: any req held continuously SHALL be granted within 3 cycles.
REQ-020 req = 3'b000: gnt = 0, rom_en = 0, pointer held.
REQ-021 frame_start = 1: pointer SHALL load 2 so that the next search starts at requester 0; if a grant also occurs in that cycle, frame_start takes precedence for the pointer value; the grant itself is unaffected.
REQ-022 A request deasserted before grant SHALL be dropped with no residual state.

Reset
REQ-023 While rst = 1: gnt = 0, rom_en = 0, rom_addr = 0, rvalid = 0, rdata = 0, pointer = 2.
REQ-024 Reset mid-transfer SHALL discard any pending rvalid; a read issued the cycle before rst rises SHALL NOT produce rvalid.
REQ-025 First cycle after rst falls with req = 3'b111 SHALL grant requester 0.

Configuration
REQ-026 Macro SPRITE_ARB_FIXED_PRI_EN, when defined, SHALL select fixed priority (0 > 1 > 2); the pointer is not implemented and REQ-014/015/019/021 do not apply.
REQ-027 Without SPRITE_ARB_FIXED_PRI_EN, round-robin per REQ-014..021 is used; all ports exist in both builds (frame_start ignored when the macro is defined).

Verification
REQ-028 Reset, then req=3'b111 held 6 cycles -> gnt sequence 001,010,100,001,010,100; rvalid matches one cycle later.
REQ-029 Single req=3'b010, addr1=17'h00100, ROM returns 12'hFDA -> gnt=010, rom_addr=17'h00100 cycle N; rvalid=010, rdata=12'hFDA cycle N+1.
REQ-030 req=3'b111, frame_start pulsed after grant to requester 0 -> next grant is requester 0, not 1.
REQ-031 rst asserted the cycle after a grant -> rvalid stays 000; after release, req=3'b110 -> gnt=010 first.
REQ-032 Idle req=0 for 5 cycles -> rom_en=0, rdata=12'h000 throughout, pointer unchanged.
REQ-033 With SPRITE_ARB_FIXED_PRI_EN, req=3'b111 for 4 cycles -> gnt=001 every cycle; requester 2 granted only when req=3'b100.
